// File: rtl/ram_rw_ctrl.sv
// rtl/ram_rw_ctrl.sv - RAM write/read-back self-test controller
// Writes a SEED-offset address pattern, reads it back and checks it through an RD_LAT-deep compare pipeline.
module ram_rw_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int DATA_W = 8,
  parameter int SEED   = 0,
  parameter int RD_LAT = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        err_cnt,
  output logic [ADDR_W-1:0] err_addr
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_DRAIN = ADDR_W'(RD_LAT - 1);
  localparam logic [DATA_W-1:0] SEED_V     = DATA_W'(SEED);

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    return SEED_V + DATA_W'(a);
  endfunction

  state_t                         state_q, state_d;
  logic [ADDR_W-1:0]              addr_q, addr_d, addr_inc;
  logic                           en_q, en_d, we_q, we_d;
  logic [DATA_W-1:0]              wdata_q, wdata_d;
  logic                           busy_q, busy_d, done_q, done_d;
  logic                           error_q, error_d;
  logic [7:0]                     err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]              err_addr_q, err_addr_d;
  logic [RD_LAT-1:0]              vld_q, vld_d;
  logic [RD_LAT-1:0][ADDR_W-1:0]  pa_q, pa_d;
  logic [RD_LAT-1:0][DATA_W-1:0]  pe_q, pe_d;

  assign addr_inc = addr_q + ADDR_W'(1);

  always_comb begin
    state_d    = state_q;
    addr_d     = '0;
    en_d       = 1'b0;
    we_d       = 1'b0;
    wdata_d    = '0;
    busy_d     = 1'b1;
    done_d     = 1'b0;
    error_d    = error_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;

    // Each read carries its address and expected word until its data returns.
    vld_d    = '0;
    pa_d     = '0;
    pe_d     = '0;
    vld_d[0] = (state_q == READ);
    pa_d[0]  = addr_q;
    pe_d[0]  = pattern(addr_q);
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      pa_d[i]  = pa_q[i-1];
      pe_d[i]  = pe_q[i-1];
    end

    if (vld_q[RD_LAT-1] && (ram_rdata != pe_q[RD_LAT-1])) begin
      error_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      if (!error_q) err_addr_d = pa_q[RD_LAT-1];
    end

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d    = WRITE;
          en_d       = 1'b1;
          we_d       = 1'b1;
          wdata_d    = pattern(ADDR_W'(0));
          busy_d     = 1'b1;
          error_d    = 1'b0;
          err_cnt_d  = '0;
          err_addr_d = '0;
        end
      end
      WRITE: begin
        en_d = 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_d = READ;
        end else begin
          we_d    = 1'b1;
          addr_d  = addr_inc;
          wdata_d = pattern(addr_inc);
        end
      end
      READ: begin
        if (addr_q == LAST_ADDR) begin
          state_d = DRAIN;
        end else begin
          en_d   = 1'b1;
          addr_d = addr_inc;
        end
      end
      DRAIN: begin
        if (addr_q == LAST_DRAIN) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else begin
          addr_d = addr_inc;
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      vld_q      <= '0;
      pa_q       <= '0;
      pe_q       <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      en_q       <= en_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      vld_q      <= vld_d;
      pa_q       <= pa_d;
      pe_q       <= pe_d;
    end
  end

  assign ram_en    = en_q;
  assign ram_we    = we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_cnt   = err_cnt_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_ram_rw_ctrl.sv
// tb/tb_ram_rw_ctrl.sv - directed self-checking bench for ram_rw_ctrl
// dut1: RD_LAT=1, SEED=0; dut2: RD_LAT=2, SEED=0xF0; each with its own RAM model.
module tb_ram_rw_ctrl;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic sys_rst_n;
  logic start1, start2;
  logic corrupt;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic       en1, we1, busy1, done1, error1;
  logic [4:0] addr1, eaddr1;
  logic [7:0] wdata1, rdata1, cnt1;
  logic       en2, we2, busy2, done2, error2;
  logic [4:0] addr2, eaddr2;
  logic [7:0] wdata2, rdata2, cnt2, rd2a;

  logic [7:0] mem1 [32];
  logic [7:0] mem2 [32];

  ram_rw_ctrl #(.ADDR_W(5), .DEPTH(32), .DATA_W(8), .SEED(0), .RD_LAT(1)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start1),
    .ram_en(en1), .ram_we(we1), .ram_addr(addr1), .ram_wdata(wdata1), .ram_rdata(rdata1),
    .busy(busy1), .done(done1), .error(error1), .err_cnt(cnt1), .err_addr(eaddr1)
  );

  ram_rw_ctrl #(.ADDR_W(5), .DEPTH(32), .DATA_W(8), .SEED(240), .RD_LAT(2)) dut2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start2),
    .ram_en(en2), .ram_we(we2), .ram_addr(addr2), .ram_wdata(wdata2), .ram_rdata(rdata2),
    .busy(busy2), .done(done2), .error(error2), .err_cnt(cnt2), .err_addr(eaddr2)
  );

  // Synchronous RAMs; model 1 can flip the data read from addresses 5 and 9.
  always @(posedge sys_clk) begin
    if (en1) begin
      if (we1) mem1[addr1] <= wdata1;
      else rdata1 <= (corrupt && (addr1 == 5'd5 || addr1 == 5'd9)) ? ~mem1[addr1] : mem1[addr1];
    end
    if (en2) begin
      if (we2) mem2[addr2] <= wdata2;
      else rd2a <= mem2[addr2];
    end
    rdata2 <= rd2a;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a run on dut <which> at edge 0, observe cycles 1..ncyc at the falling edge.
  task automatic run(input int which, input int p1, input int p2, input int rst_at,
                     input int ncyc, output int dcyc, output int dn, output int acc);
    logic       o_en, o_we, o_busy, o_done, o_err;
    logic [4:0] o_addr, o_eaddr;
    logic [7:0] o_wdata, o_cnt, seed;
    int         lat;
    seed = (which == 2) ? 8'hF0 : 8'h00;
    lat  = (which == 2) ? 2 : 1;
    dcyc = -1; dn = 0; acc = 0;
    @(negedge sys_clk);
    if (which == 2) start2 = 1'b1; else start1 = 1'b1;
    @(posedge sys_clk);
    #1;
    start1 = 1'b0; start2 = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge sys_clk);
      if (which == 2) begin
        o_en = en2; o_we = we2; o_addr = addr2; o_wdata = wdata2; o_busy = busy2;
        o_done = done2; o_err = error2; o_cnt = cnt2; o_eaddr = eaddr2;
      end else begin
        o_en = en1; o_we = we1; o_addr = addr1; o_wdata = wdata1; o_busy = busy1;
        o_done = done1; o_err = error1; o_cnt = cnt1; o_eaddr = eaddr1;
      end
      if (o_done) begin dn++; dcyc = c; end
      if (o_en) acc++;
      if (c == 1) begin
        chk("c1_en_we", 32'({o_en, o_we, o_busy}), 32'h7);
        chk("c1_addr_wdata", 32'({o_addr, o_wdata}), 32'({5'd0, seed}));
        chk("c1_errs_cleared", 32'({o_err, o_cnt, o_eaddr}), 32'd0);
      end
      if (rst_at == 0) begin
        if (c == 32) chk("c32_last_write", 32'({o_we, o_addr, o_wdata}), 32'({1'b1, 5'd31, seed + 8'd31}));
        if (c == 33) chk("c33_first_read", 32'({o_en, o_we, o_addr, o_wdata}), 32'({1'b1, 1'b0, 5'd0, 8'd0}));
        if (c == 65) chk("c65_drain", 32'({o_en, o_we, o_busy, o_done}), 32'b0010);
        if (c == 66 + lat) chk("fin_to_idle", 32'({o_busy, o_done}), 32'd0);
      end
      if (which == 2) start2 = (c == p1 || c == p2);
      else start1 = (c == p1 || c == p2);
      if (c == rst_at) begin
        sys_rst_n = 1'b0;
        #1;
        chk("rst_outputs_zero", 32'({en1, we1, addr1, wdata1, busy1, done1, error1, cnt1, eaddr1}), 32'd0);
      end
      if (rst_at != 0 && c == rst_at + 2) sys_rst_n = 1'b1;
    end
    start1 = 1'b0; start2 = 1'b0;
  endtask

  int dcyc, dn, acc, got_done;

  initial begin
    sys_rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; corrupt = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("reset_dut1", 32'({en1, we1, addr1, wdata1, busy1, done1, error1, cnt1, eaddr1}), 32'd0);
    chk("reset_dut2", 32'({en2, we2, addr2, wdata2, busy2, done2, error2, cnt2, eaddr2}), 32'd0);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("idle_no_access", 32'({en1, busy1, en2, busy2}), 32'd0);

    // Clean run, RD_LAT=1.
    run(1, 0, 0, 0, 70, dcyc, dn, acc);
    chk("clean_done_cycle", 32'(dcyc), 32'd66);
    chk("clean_done_count", 32'(dn), 32'd1);
    chk("clean_accesses", 32'(acc), 32'd64);
    chk("clean_errors", 32'({error1, cnt1}), 32'd0);
    chk("clean_mem0", 32'(mem1[0]), 32'h00);
    chk("clean_mem17", 32'(mem1[17]), 32'h11);
    chk("clean_mem31", 32'(mem1[31]), 32'h1F);

    // Reads of addresses 5 and 9 corrupted.
    corrupt = 1'b1;
    run(1, 0, 0, 0, 70, dcyc, dn, acc);
    corrupt = 1'b0;
    chk("corrupt_done_cycle", 32'(dcyc), 32'd66);
    chk("corrupt_error", 32'(error1), 32'd1);
    chk("corrupt_err_cnt", 32'(cnt1), 32'd2);
    chk("corrupt_err_addr", 32'(eaddr1), 32'd5);
    repeat (3) @(negedge sys_clk);
    chk("corrupt_result_held", 32'({error1, cnt1, eaddr1}), 32'({1'b1, 8'd2, 5'd5}));

    // Clean run after the failing one; start pulses mid-run must be ignored.
    run(1, 10, 40, 0, 70, dcyc, dn, acc);
    chk("ignore_done_cycle", 32'(dcyc), 32'd66);
    chk("ignore_done_count", 32'(dn), 32'd1);
    chk("ignore_accesses", 32'(acc), 32'd64);
    chk("second_run_clean", 32'({error1, cnt1, eaddr1}), 32'd0);

    // Reset asserted in cycle 20 for two cycles.
    run(1, 0, 0, 20, 70, dcyc, dn, acc);
    chk("rst_no_done", 32'(dn), 32'd0);
    chk("rst_accesses", 32'(acc), 32'd20);
    chk("rst_idle_after", 32'({busy1, en1}), 32'd0);

    // RD_LAT=2, SEED=0xF0.
    run(2, 0, 0, 0, 72, dcyc, dn, acc);
    chk("lat2_done_cycle", 32'(dcyc), 32'd67);
    chk("lat2_done_count", 32'(dn), 32'd1);
    chk("lat2_accesses", 32'(acc), 32'd64);
    chk("lat2_errors", 32'({error2, cnt2}), 32'd0);
    chk("lat2_mem0", 32'(mem2[0]), 32'hF0);
    chk("lat2_mem31_wrap", 32'(mem2[31]), 32'h0F);

    // start held high: next run begins at the first IDLE cycle after FIN.
    @(negedge sys_clk);
    start1 = 1'b1;
    @(posedge sys_clk);
    for (int c = 1; c <= 69; c++) begin
      @(negedge sys_clk);
      if (c == 66) chk("hold_done", 32'(done1), 32'd1);
      if (c == 67) chk("hold_idle_gap", 32'({en1, busy1, done1}), 32'd0);
      if (c == 68) chk("hold_restart", 32'({en1, we1, addr1, busy1}), 32'({1'b1, 1'b1, 5'd0, 1'b1}));
    end
    start1 = 1'b0;
    got_done = 0;
    for (int c = 0; c < 120 && got_done == 0; c++) begin
      @(negedge sys_clk);
      if (done1) got_done = 1;
    end
    chk("hold_second_done", 32'(got_done), 32'd1);
    @(negedge sys_clk);
    chk("hold_back_idle", 32'({busy1, en1, error1}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
